// File: rtl/elc3_pkg.sv
// Shared eLC-3 definitions: display shifter states, DSR bit positions and
// the memory-mapped addresses of the display registers.
package elc3_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int DSR_READY = 15;
    localparam int DSR_IE    = 14;

    localparam logic [15:0] ADDR_DSR = 16'hFE04;
    localparam logic [15:0] ADDR_DDR = 16'hFE06;

endpackage

// File: rtl/uart_display_if.sv
// eLC-3 bus view of the display device: register selects, write strobe and
// data paths as seen from the address decoder side.
interface uart_display_if;
    logic        DSR_Sel;
    logic        DDR_Sel;
    logic        Write;
    logic [15:0] Data_In;
    logic [15:0] Data_Out;

    modport master (output DSR_Sel, DDR_Sel, Write, Data_In, input Data_Out);
    modport slave  (input DSR_Sel, DDR_Sel, Write, Data_In, output Data_Out);
endinterface

// File: rtl/uart_tx_shifter.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, each held for
// CLKS_PER_BIT cycles. Accepts a new byte in IDLE or on the final stop cycle.
module uart_tx_shifter
    import elc3_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              baud_done;

    assign baud_done = (baud_q == BAUD_LAST);
    // Free to take a byte now: idle, or the last stop cycle (gapless chaining).
    assign busy_o    = !((state_q == IDLE) || ((state_q == STOP) && baud_done));
    assign tx_o      = tx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (load_i) begin
                        shift_q <= data_i;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (load_i) begin
                            shift_q <= data_i;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_display.sv
// LC-3 display device: DSR/DDR registers with a one-byte holding buffer in
// front of the UART shifter; Irq raised when IE is set and the buffer is empty.
module uart_display
    import elc3_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           Clk,
    input  logic           Reset,
    uart_display_if.slave  bus,
    output logic           Tx,
    output logic           Irq
);

    logic [7:0]  hold_q, hold_d;
    logic        full_q, full_d;
    logic        ie_q, ie_d;
    logic        irq_q;
    logic        sh_busy;
    logic        take;
    logic [15:0] dsr_val;
    logic        unused_din;

    assign take       = full_q && !sh_busy;
    assign unused_din = ^{bus.Data_In[15], bus.Data_In[13:8]};

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        ie_d   = ie_q;
        if (take) full_d = 1'b0;
        // take needs a full buffer and a DDR write needs an empty one, so they never collide
        if (bus.Write) begin
            if (bus.DSR_Sel) begin
                ie_d = bus.Data_In[DSR_IE];
            end else if (bus.DDR_Sel && !full_q) begin
                hold_d = bus.Data_In[7:0];
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
            ie_q   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            ie_q   <= ie_d;
            irq_q  <= ie_d && !full_d;
        end
    end

    always_comb begin
        dsr_val            = '0;
        dsr_val[DSR_READY] = !full_q;
        dsr_val[DSR_IE]    = ie_q;
    end

    assign bus.Data_Out = bus.DSR_Sel ? dsr_val :
                          bus.DDR_Sel ? {8'h00, hold_q} : 16'h0000;
    assign Irq = irq_q;

    uart_tx_shifter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_shifter (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .load_i (take),
        .data_i (hold_q),
        .busy_o (sh_busy),
        .tx_o   (Tx)
    );

endmodule

// File: tb/tb_uart_display.sv
// Directed and random bus traffic against a cycle-level frame-timing model
// of the display device, with CLKS_PER_BIT = 4.
module tb_uart_display;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, irq;
    int   errors = 0;
    int   checks = 0;

    // reference state
    int         cyc = 0;
    bit         m_full = 0, m_ie = 0, m_act = 0;
    logic [7:0] m_hold = 8'h00, m_byte = 8'h00;
    int         m_start = 0, m_free = 0;

    uart_display_if bus ();

    uart_display #(.CLKS_PER_BIT(CPB)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave),
        .Tx    (tx),
        .Irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive, advance the model by one edge, then compare all outputs.
    task automatic step(input bit dsr, input bit ddr, input bit wr,
                        input logic [15:0] din, input bit r);
        bit         pre_full;
        int         k;
        logic       exp_tx;
        logic [15:0] exp_dout;
        bus.DSR_Sel = dsr;
        bus.DDR_Sel = ddr;
        bus.Write   = wr;
        bus.Data_In = din;
        rst         = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_full = 0; m_ie = 0; m_act = 0; m_hold = 8'h00; m_free = 0;
        end else begin
            pre_full = m_full;
            if (m_act && cyc >= m_start + FRAME) m_act = 0;
            if (pre_full && cyc >= m_free) begin
                m_act = 1; m_start = cyc; m_byte = m_hold;
                m_free = cyc + FRAME; m_full = 0;
            end
            if (wr && dsr) m_ie = din[14];
            else if (wr && ddr && !pre_full) begin
                m_hold = din[7:0]; m_full = 1;
            end
        end
        #1;
        exp_tx = 1'b1;
        if (m_act) begin
            k = (cyc - m_start) / CPB;
            if (k == 0) exp_tx = 1'b0;
            else if (k <= 8) exp_tx = m_byte[k-1];
        end
        if (dsr)      exp_dout = {~m_full, m_ie, 14'h0};
        else if (ddr) exp_dout = {8'h00, m_hold};
        else          exp_dout = 16'h0000;
        chk("tx",   {15'h0, tx},  {15'h0, exp_tx});
        chk("irq",  {15'h0, irq}, {15'h0, m_ie & ~m_full});
        chk("dout", bus.Data_Out, exp_dout);
    endtask

    initial begin
        logic [9:0] pat_a;
        bit         d, s, w, r;
        pat_a = 10'b10_1000_0010;

        // reset and idle
        step(1, 0, 0, 16'h0, 1);
        step(1, 0, 0, 16'h0, 1);
        chk("reset_dsr", bus.Data_Out, 16'h8000);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 16'h0, 0);

        // single frame 'A', mid-bit samples
        step(0, 1, 1, 16'h0041, 0);
        for (int i = 0; i < FRAME; i++) begin
            step(1, 0, 0, 16'h0, 0);
            if (i == 0) begin
                chk("a_txfall", {15'h0, tx}, 16'h0000);
                chk("a_ready",  bus.Data_Out, 16'h8000);
            end
            if (i % CPB == 2) chk("a_bit", {15'h0, tx}, {15'h0, pat_a[i/CPB]});
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0, 0);

        // back-to-back 'H','i'
        step(0, 1, 1, 16'h0048, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 16'h0, 0);
        step(0, 1, 1, 16'h0069, 0);
        for (int i = 0; i < 80; i++) step(1, 0, 0, 16'h0, 0);

        // 'A','B' accepted, 'C' dropped while full
        step(0, 1, 1, 16'h0041, 0);
        step(1, 0, 0, 16'h0, 0);
        step(0, 1, 1, 16'h0042, 0);
        step(0, 1, 1, 16'h0043, 0);
        for (int i = 0; i < 90; i++) step(0, 1, 0, 16'h0, 0);
        chk("abc_ddr", bus.Data_Out, 16'h0042);

        // interrupt enable
        step(1, 0, 1, 16'h4000, 0);
        chk("ie_dsr", bus.Data_Out, 16'hC000);
        step(1, 0, 0, 16'h0, 0);
        chk("ie_irq", {15'h0, irq}, 16'h0001);
        step(0, 1, 1, 16'h0055, 0);
        chk("irq_low", {15'h0, irq}, 16'h0000);
        for (int i = 0; i < 50; i++) step(1, 0, 0, 16'h0, 0);

        // reset in data bit 3
        step(0, 1, 1, 16'h005A, 0);
        for (int i = 0; i < 18; i++) step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 1);
        chk("rst_tx",  {15'h0, tx}, 16'h0001);
        chk("rst_dsr", bus.Data_Out, 16'h8000);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 16'h0, 0);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 5) == 0);
            if (w) begin
                s = $urandom_range(0, 3) == 0;
                d = !s;
            end else begin
                s = $urandom_range(0, 1) == 1;
                d = $urandom_range(0, 1) == 1;
            end
            step(s, d, w, 16'($urandom), r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_display.md
# uart_display

Memory-mapped LC-3 display device for the eLC-3, the output counterpart of the keyboard input path. The CPU writes characters to the Display Data Register (DDR) and polls or takes interrupts from the Display Status Register (DSR). Each accepted character is serialized as 8N1 UART on a single `Tx` pin. The block sits on the eLC-3 memory bus behind the address decoder, which supplies the DSR and DDR selects.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per UART bit (50 MHz / 115200); legal range is 2 or more.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `DSR_Sel`  in  1  bus access targets the DSR (xFE04).
- `DDR_Sel`  in  1  bus access targets the DDR (xFE06).
- `Write`  in  1  bus write strobe; qualified by a select.
- `Data_In`  in  16  bus write data.
- `Data_Out`  out  16  bus read data.
- `Tx`  out  1  serial line; idles high.
- `Irq`  out  1  interrupt request, equal to IE AND Ready.

## Operation
- DSR read value: bit 15 = Ready, bit 14 = IE, all other bits 0.
- DSR write: Data_In[14] loads IE; bit 15 is read-only; other bits are ignored.
- DDR read value: {8'h00, holding byte}.
- `Data_Out` is combinational:
  - DSR value when `DSR_Sel` is high.
  - DDR value when `DDR_Sel` is high.
  - x0000 when neither is high.
  - If both selects are high, DSR wins.
- Buffering is one holding byte plus one shift register. Ready = holding byte empty.
- DDR write rules:
  - Accepted only if Ready = 1 at the sampling edge. An accepted write latches Data_In[7:0] into the holding byte and marks it full.
  - A write while Ready = 0 is dropped silently, with no state change.
- Shifter FSM states are IDLE, START, DATA and STOP:
  - IDLE: `Tx` = 1. If the holding byte is full: load the shift register, empty the holding byte, go to START.
  - START: `Tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `Tx` = shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. 8 bits, LSB first, counted by a 3-bit counter; go to STOP after bit 7.
  - STOP: `Tx` = 1 for CLKS_PER_BIT cycles. At the last cycle:
    - Holding byte full: load it and go directly to START (gapless back-to-back frames).
    - Otherwise: go to IDLE.
- The baud counter runs from 0 to CLKS_PER_BIT-1 and is cleared on every state entry. Its width is $clog2(CLKS_PER_BIT).
- Reset values:
  - State IDLE, `Tx` = 1.
  - Holding byte empty (Ready = 1), holding data 0.
  - IE = 0, `Irq` = 0.
  - Counters 0.
- Reset mid-frame: the frame is aborted and `Tx` returns high on the edge after `Reset` is sampled. The pending holding byte is discarded.
- A DSR write and a DDR write cannot occur in the same cycle, because only one select is active per access.

## Timing
- DDR write accepted at edge N (IDLE, empty):
  - Ready = 0 after edge N.
  - At edge N+1: shifter loads, holding byte empties, Ready = 1, and `Tx` falls (start bit begins).
- Frame length is exactly 10 × CLKS_PER_BIT cycles from the `Tx` falling edge to the end of the stop bit.
- A second write accepted during a frame is sent with 0 idle cycles after the stop bit. Ready rises on the edge the second byte is loaded.
- `Tx`, Ready, IE and `Irq` are registered outputs, with no combinational path from bus inputs. `Data_Out` is the only combinational output.

## Structure
- Shared package `elc3_pkg` holds:
  - `uart_state_t` enum (IDLE, START, DATA, STOP).
  - DSR bit-index constants DSR_READY = 15 and DSR_IE = 14.
  - Address constants ADDR_DSR = 16'hFE04 and ADDR_DDR = 16'hFE06.
- Sub-module `uart_tx_shifter` contains the FSM, baud counter, bit counter and shift register. Its interface is: load pulse, 8-bit data, `busy`/`take` handshake, and `Tx`.
- `uart_display` wraps `uart_tx_shifter` with the DSR/DDR registers, holding byte and read mux.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Reset, then read DSR → x8000; `Tx` = 1 and `Irq` = 0 held for 20 idle cycles.
- Write DDR x0041 → `Tx` falls 1 cycle later. Bits sampled mid-bit every 4 cycles read 0,1,0,0,0,0,0,1,0,1. Ready returns to 1 one cycle after the write.
- Write x0048 then, mid-frame, x0069 → second frame starts on the cycle after the first stop bit ends. The 80 serial cycles decode to 'H','i'.
- Write x0041, x0042 and a third x0043 while Ready = 0 → x0043 is dropped. Only 'A','B' appear on `Tx`, and a DDR read returns x0042 until the next write.
- Write DSR x4000 → DSR reads xC000 and `Irq` = 1. Then write DDR x0055 → `Irq` stays 0 while the holding byte is full and returns to 1 when it is loaded into the shifter.
- Assert `Reset` during data bit 3 → `Tx` = 1 on the next cycle, DSR reads x8000, and no further frame bits appear.
